exp2_bf16: RTL and testbench

- Computes 2^x for one bfloat16 operand. This is the inverse of the log2 datapath.
- Output is a bfloat16 result with sign, exponent and fraction fields identical to the log2 block's output.
- Algorithm:
  - special-case detection;
  - float-to-fixed split into an integer part n and a fraction f;
  - iterative 8-step shift-multiply over a constant ROM computes 2^f;
  - pack/round into the result fields.
- Sits beside the log2 unit in the bfloat16 math cluster, behind the same valid/ready handshake.

---
 rtl/exp2_bf16_if.sv | 26 ++
 rtl/exp2_bf16.sv | 181 ++++++++++++++++++
 tb/tb_exp2_bf16.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/exp2_bf16_if.sv
// Operand/result handshake bundle for the bfloat16 exp2 unit.
// The master drives the operand and valid_i; the slave (exp2_bf16) returns ready_o and the result.
interface exp2_bf16_if #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7
);
  logic                   sign;
  logic [EXP_WIDTH-1:0]   exponent;
  logic [FRACT_WIDTH-1:0] fractional;
  logic                   valid_i;
  logic                   ready_o;
  logic                   s_res_o;
  logic [EXP_WIDTH-1:0]   e_res_o;
  logic [FRACT_WIDTH-1:0] f_res_o;
  logic                   valid_o;

  modport master (
    output sign, exponent, fractional, valid_i,
    input  ready_o, s_res_o, e_res_o, f_res_o, valid_o
  );

  modport slave (
    input  sign, exponent, fractional, valid_i,
    output ready_o, s_res_o, e_res_o, f_res_o, valid_o
  );
endinterface

// File: rtl/exp2_bf16.sv
// bfloat16 2^x: special-case decode, Q8.8 split, 8-step shift-multiply over a constant ROM, pack.
// Define EXP2_ROUND_EN for round-half-up of the result mantissa; otherwise it is truncated.
module exp2_bf16 #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7,
  parameter int BIAS        = 127
) (
  input  logic          clk,
  input  logic          rst,
  exp2_bf16_if.slave    bus
);

  localparam int RW = 1 + EXP_WIDTH + FRACT_WIDTH;

  typedef enum logic [2:0] {IDLE, DECODE, ITER, PACK, DONE} state_t;

  state_t state, state_n;

  logic                   op_sign;
  logic [EXP_WIDTH-1:0]   op_exp;
  logic [FRACT_WIDTH-1:0] op_frac;

  logic signed [8:0]      n_int;
  logic [7:0]             f_frac;
  logic [15:0]            acc;
  logic [3:0]             k;
  logic [RW-1:0]          res;
  logic                   vld;

  function automatic logic [15:0] rom(input logic [3:0] idx);
    case (idx)
      4'd1:    rom = 16'd46341;
      4'd2:    rom = 16'd38968;
      4'd3:    rom = 16'd35734;
      4'd4:    rom = 16'd34219;
      4'd5:    rom = 16'd33486;
      4'd6:    rom = 16'd33125;
      4'd7:    rom = 16'd32946;
      4'd8:    rom = 16'd32857;
      default: rom = 16'd32768;
    endcase
  endfunction

  // acc holds 2^f in Q1.15, so bit 15 is the hidden one and bits 14:8 the stored fraction.
  function automatic logic [RW-1:0] pack(input logic signed [8:0] n_v, input logic [15:0] a);
    logic signed [9:0] e;
    logic [7:0]        m8;
    logic [15:0]       t;
    e = $signed({n_v[8], n_v}) + 10'(BIAS);
`ifdef EXP2_ROUND_EN
    t  = {1'b0, a[14:0]} + 16'h0080;
    m8 = 8'(t >> 8);
    if (m8[7]) begin
      e = e + 10'sd1;
    end
`else
    t  = a;
    m8 = {1'b0, 7'(t >> 8)};
`endif
    if (e >= 10'sd255) begin
      pack = RW'(16'h7F80);
    end else if (e <= 10'sd0) begin
      pack = '0;
    end else begin
      pack = {1'b0, e[EXP_WIDTH-1:0], m8[FRACT_WIDTH-1:0]};
    end
  endfunction

  logic                   special;
  logic [RW-1:0]          special_res;
  logic [FRACT_WIDTH:0]   m;
  logic signed [9:0]      sh;
  logic [9:0]             rsh;
  logic [15:0]            mag;
  logic signed [16:0]     x_fix;
  logic [31:0]            prod;
  logic [15:0]            acc_mul;
  logic [2:0]             fidx;

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (op_exp == '1) begin
      if (op_frac != '0)  special_res = RW'(16'h7FC0);
      else if (op_sign)   special_res = '0;
      else                special_res = RW'(16'h7F80);
    end else if (op_exp == '0) begin
      special_res = RW'(16'h3F80);
    end else if (op_exp >= EXP_WIDTH'(BIAS + 7)) begin
      special_res = op_sign ? '0 : RW'(16'h7F80);
    end else begin
      special = 1'b0;
    end
  end

  // Operand as Q8.8 magnitude: value = m * 2^(exp-BIAS-7), times 256 gives m << (exp-126).
  always_comb begin
    m   = {1'b1, op_frac};
    sh  = $signed({2'b00, op_exp}) - 10'(BIAS - 1);
    rsh = 10'(-sh);
    mag = '0;
    if (sh >= 10'sd0) begin
      mag = 16'(m) << sh[2:0];
    end else if (rsh[9:3] == '0) begin
      mag = 16'(m) >> rsh[2:0];
    end
    x_fix = op_sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

  assign prod    = 32'(acc) * 32'(rom(k));
  assign acc_mul = 16'(prod >> 15);
  assign fidx    = 3'(4'd8 - k);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.valid_i) state_n = DECODE;
      DECODE:  state_n = special ? DONE : ITER;
      ITER:    if (k == 4'd8) state_n = PACK;
      PACK:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture and the n/f split carry no reset: they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.valid_i) begin
      op_sign <= bus.sign;
      op_exp  <= bus.exponent;
      op_frac <= bus.fractional;
    end
    if (state == DECODE) begin
      n_int  <= x_fix[16:8];
      f_frac <= x_fix[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      k   <= '0;
      res <= '0;
      vld <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        DECODE: begin
          if (special) begin
            res <= special_res;
            vld <= 1'b1;
          end else begin
            acc <= 16'h8000;
            k   <= 4'd1;
          end
        end
        ITER: begin
          if (f_frac[fidx]) acc <= acc_mul;
          k <= k + 4'd1;
        end
        PACK: begin
          res <= pack(n_int, acc);
          vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = vld;
  assign bus.s_res_o = res[RW-1];
  assign bus.e_res_o = res[RW-2:FRACT_WIDTH];
  assign bus.f_res_o = res[FRACT_WIDTH-1:0];

endmodule

// File: tb/tb_exp2_bf16.sv
// Directed-vector bench for exp2_bf16: table of operands with hand-computed results and latencies,
// plus sequences for a valid_i pulse during iteration and a reset in the middle of iteration.
module tb_exp2_bf16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exp2_bf16_if bus ();

  exp2_bf16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] result();
    return {bus.s_res_o, bus.e_res_o, bus.f_res_o};
  endfunction

  task automatic drive(input logic [15:0] x, input logic v);
    bus.sign       = x[15];
    bus.exponent   = x[14:7];
    bus.fractional = x[6:0];
    bus.valid_i    = v;
  endtask

  // Presents x for one edge; lat counts edges after acceptance until valid_o (-1 if it never came).
  task automatic run_op(input string nm, input logic [15:0] x, output logic [15:0] res, output int lat);
    @(negedge clk);
    check({nm, "_ready_idle"}, 32'(bus.ready_o), 32'd1);
    drive(x, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    check({nm, "_ready_busy"}, 32'(bus.ready_o), 32'd0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    res = result();
  endtask

  initial begin
    logic [15:0] res;
    int          lat;
    int          pulses;

    checks = 0;
    errors = 0;

    vecs[0]  = '{16'h3F80, 16'h4000, 10, "one"};
    vecs[1]  = '{16'h3F00, 16'h3FB5, 10, "half"};
    vecs[2]  = '{16'hBF80, 16'h3F00, 10, "neg_one"};
    vecs[3]  = '{16'h42FE, 16'h7F00, 10, "x127"};
`ifdef EXP2_ROUND_EN
    vecs[4]  = '{16'h3E00, 16'h3F8C, 10, "eighth"};
`else
    vecs[4]  = '{16'h3E00, 16'h3F8B, 10, "eighth"};
`endif
    vecs[5]  = '{16'h4000, 16'h4080, 10, "two"};
    vecs[6]  = '{16'hBF00, 16'h3F35, 10, "neg_half"};
    vecs[7]  = '{16'hC2FE, 16'h0000, 10, "underflow_m127"};
    vecs[8]  = '{16'h4040, 16'h4100, 10, "three"};
    vecs[9]  = '{16'h3FC0, 16'h4035, 10, "one_half"};
    vecs[10] = '{16'h3F40, 16'h3FD7, 10, "three_quarter"};
    vecs[11] = '{16'h3000, 16'h3F80, 10, "tiny_shift_out"};
    vecs[12] = '{16'h3B80, 16'h3F80, 10, "lsb_only"};
    vecs[13] = '{16'h7FC1, 16'h7FC0, 1,  "nan"};
    vecs[14] = '{16'hFFC1, 16'h7FC0, 1,  "neg_nan"};
    vecs[15] = '{16'h7F80, 16'h7F80, 1,  "pos_inf"};
    vecs[16] = '{16'hFF80, 16'h0000, 1,  "neg_inf"};
    vecs[17] = '{16'h0000, 16'h3F80, 1,  "zero"};
    vecs[18] = '{16'h0001, 16'h3F80, 1,  "subnormal"};
    vecs[19] = '{16'h4300, 16'h7F80, 1,  "x128"};
    vecs[20] = '{16'hC302, 16'h0000, 1,  "x_m130"};
    vecs[21] = '{16'h8000, 16'h3F80, 1,  "neg_zero"};

    rst = 1'b1;
    drive(16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_result", 32'(result()), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].x, res, lat);
      check({vecs[i].name, "_result"}, 32'(res), 32'(vecs[i].y));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      @(posedge clk);
      #1;
      check({vecs[i].name, "_strobe_end"}, {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
    end

    // valid_i raised mid-iteration must be dropped: one result, for the first operand.
    @(negedge clk);
    drive(16'h3F80, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(16'h4000, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    lat = -1;
    for (int c = 5; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    check("busy_pulse_result", 32'(result()), 32'h4000);
    check("busy_pulse_latency", 32'(lat), 32'd10);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) pulses++;
    end
    check("busy_pulse_no_second", 32'(pulses), 32'd0);

    // Reset while at ITER k=4 aborts the operation silently.
    @(negedge clk);
    drive(16'h3F00, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_ready", 32'(bus.ready_o), 32'd1);
    check("midreset_valid", 32'(bus.valid_o), 32'd0);
    check("midreset_result", 32'(result()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) pulses++;
    end
    check("midreset_no_result", 32'(pulses), 32'd0);
    run_op("after_reset", 16'h3F80, res, lat);
    check("after_reset_result", 32'(res), 32'h4000);
    check("after_reset_latency", 32'(lat), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
